// File: rtl/demux1x4_stream.sv
// 1-to-4 valid/ready stream demultiplexer with a one-entry holding register per channel.
// Optional build macro DEMUX_CNT_EN adds per-channel 8-bit drain counters on cnt_flat.
module demux1x4_stream #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3
`ifdef DEMUX_CNT_EN
    ,
    output logic [31:0]       cnt_flat
`endif
);

    logic [3:0]        vld_q, vld_d;
    logic [DATA_W-1:0] dat_q [4];
    logic [DATA_W-1:0] dat_d [4];
    logic [3:0]        drn;
    logic              acc;

    // A full channel can still take a beat in the same cycle it drains.
    assign in_ready = ~rst & (~vld_q[in_sel] | out_ready[in_sel]);
    assign acc      = in_valid & in_ready;
    assign drn      = vld_q & out_ready;

    always_comb begin
        vld_d = vld_q;
        for (int k = 0; k < 4; k++) begin
            dat_d[k] = dat_q[k];
            if (acc && (in_sel == 2'(k))) begin
                dat_d[k] = in_data;
                vld_d[k] = 1'b1;
            end else if (drn[k]) begin
                vld_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < 4; k++) dat_q[k] <= '0;
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < 4; k++) dat_q[k] <= dat_d[k];
        end
    end

    assign out_valid = vld_q;
    assign out_data0 = dat_q[0];
    assign out_data1 = dat_q[1];
    assign out_data2 = dat_q[2];
    assign out_data3 = dat_q[3];

`ifdef DEMUX_CNT_EN
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];

    // Counters wrap silently at 255.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = drn[k] ? cnt_q[k] + 8'd1 : cnt_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign cnt_flat = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_demux1x4_stream.sv
// Testbench for demux1x4_stream: directed scenarios plus random traffic against a
// per-channel queue model (capacity one). Define DEMUX_CNT_EN to exercise cnt_flat.
module tb_demux1x4_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_sel;
    logic [7:0] in_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data0, out_data1, out_data2, out_data3;
`ifdef DEMUX_CNT_EN
    logic [31:0] cnt_flat;
`endif

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] mq [4][$];
    logic [7:0] lastd [4];
    logic [7:0] mcnt [4];

    always #5 clk = ~clk;

    demux1x4_stream #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1),
        .out_data2(out_data2), .out_data3(out_data3)
`ifdef DEMUX_CNT_EN
        , .cnt_flat(cnt_flat)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dout(input int k);
        case (k)
            0: return out_data0;
            1: return out_data1;
            2: return out_data2;
            default: return out_data3;
        endcase
    endfunction

    function automatic logic [7:0] mexp(input int k);
        if (mq[k].size() != 0) return mq[k][0];
        return lastd[k];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mq[k].delete();
            lastd[k] = 8'h00;
            mcnt[k]  = 8'h00;
        end
    endtask

    // One clock: drive inputs, compare DUT against the model, then advance the model at the edge.
    task automatic cyc(input logic r, input logic iv, input logic [1:0] s,
                       input logic [7:0] d, input logic [3:0] ordy);
        logic rdy_exp;
        rst = r; in_valid = iv; in_sel = s; in_data = d; out_ready = ordy;
        #3;
        rdy_exp = !r && (mq[s].size() == 0 || ordy[s]);
        chk("in_ready", 32'(in_ready), 32'(rdy_exp));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("out_valid%0d", k), 32'(out_valid[k]), 32'(mq[k].size() != 0));
            chk($sformatf("out_data%0d", k), 32'(dout(k)), 32'(mexp(k)));
        end
`ifdef DEMUX_CNT_EN
        chk("cnt_flat", cnt_flat, {mcnt[3], mcnt[2], mcnt[1], mcnt[0]});
`endif
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (ordy[k] && mq[k].size() != 0) begin
                    void'(mq[k].pop_front());
                    mcnt[k] = mcnt[k] + 8'd1;
                end
            end
            if (iv && rdy_exp) begin
                mq[s].push_back(d);
                lastd[s] = d;
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'h0;
        @(posedge clk); #1;
        model_reset();

        // Reset with a beat presented: nothing accepted, outputs cleared.
        cyc(1, 1, 2'd2, 8'h5A, 4'h0);
        cyc(1, 1, 2'd2, 8'h5A, 4'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        cyc(0, 0, 2'd0, 8'h00, 4'h0);

        // Single route to channel 1, hold, then drain.
        cyc(0, 1, 2'd1, 8'hA5, 4'h0);
        chk("single_vld", 32'(out_valid), 32'h2);
        chk("single_d1", 32'(out_data1), 32'hA5);
        for (int i = 0; i < 5; i++) cyc(0, 0, 2'd3, 8'hFF, 4'h0);
        chk("single_hold", 32'(out_data1), 32'hA5);
        cyc(0, 0, 2'd0, 8'h00, 4'b0010);
        chk("single_drained", 32'(out_valid), 32'h0);

        // Backpressure on channel 3, channel 0 still reachable.
        cyc(0, 1, 2'd3, 8'h33, 4'h0);
        cyc(0, 1, 2'd3, 8'h11, 4'h0);
        chk("bp_d3", 32'(out_data3), 32'h33);
        cyc(0, 1, 2'd0, 8'h22, 4'h0);
        chk("bp_d0", 32'(out_data0), 32'h22);
        chk("bp_d3_still", 32'(out_data3), 32'h33);

        // Streaming into channel 2 with all consumers ready.
        cyc(0, 0, 2'd0, 8'h00, 4'hF);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, 2'd2, 8'(i), 4'hF);
            chk("stream_d2", 32'(out_data2), 32'(i));
            chk("stream_v2", 32'(out_valid[2]), 32'h1);
        end
        cyc(0, 0, 2'd0, 8'h00, 4'hF);

        // Round robin fill, then a blocked fifth beat.
        cyc(0, 1, 2'd0, 8'h10, 4'h0);
        cyc(0, 1, 2'd1, 8'h20, 4'h0);
        cyc(0, 1, 2'd2, 8'h30, 4'h0);
        cyc(0, 1, 2'd3, 8'h40, 4'h0);
        chk("rr_vld", 32'(out_valid), 32'hF);
        chk("rr_data", {out_data3, out_data2, out_data1, out_data0}, 32'h40302010);
        cyc(0, 1, 2'd0, 8'h50, 4'h0);
        chk("rr_blocked_d0", 32'(out_data0), 32'h10);
        cyc(0, 1, 2'd0, 8'h50, 4'b0001);
        chk("rr_refill_d0", 32'(out_data0), 32'h50);
        chk("rr_refill_vld", 32'(out_valid), 32'hF);

        // Reset mid-transfer discards everything.
        cyc(1, 1, 2'd1, 8'h77, 4'h0);
        chk("midrst_vld", 32'(out_valid), 32'h0);

`ifdef DEMUX_CNT_EN
        for (int i = 0; i < 258; i++) cyc(0, (i < 257), 2'd0, 8'(i), 4'b0001);
        chk("cnt_wrap", cnt_flat, 32'h00000001);
        cyc(1, 0, 2'd0, 8'h00, 4'h0);
        chk("cnt_rst", cnt_flat, 32'h0);
`endif

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                2'($urandom_range(0, 3)), 8'($urandom),
                ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
